dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default geometry.
package dmem_responder_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StWait = 1'b1
   } state_e;

   localparam int unsigned DefLatency = 2;
   localparam int unsigned DefAddrW   = 14;
   // Wide enough for the largest legal latency (15).
   localparam int unsigned CntW       = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with a combinational read port and a byte-masked synchronous write port.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata,
   input  logic              wen,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wmask
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [31:0] mem [Depth];

   assign rdata = mem[raddr];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wen) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
               mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: latches a request, counts down, then commits the access.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned LATENCY = DefLatency,
   parameter int unsigned ADDR_W  = DefAddrW
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        write_finish
);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                we_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [31:0]         wdata_q;
   logic [3:0]          wmask_q;
   logic [31:0]         rdata_q;

   logic                load;
   logic                commit;
   logic                rd_commit;
   logic                wr_commit;
   logic [31:0]         arr_rdata;
   logic                unused_addr;

   assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en) begin
               load    = 1'b1;
               cnt_d   = CntW'(LATENCY - 1);
               state_d = StWait;
            end
         end
         StWait: begin
            if (!en) begin
               // Initiator withdrew the request: abandon it silently.
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               commit  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign rd_commit    = commit & ~we_q;
   assign wr_commit    = commit & we_q;
   assign rdata_valid  = rd_commit;
   assign write_finish = wr_commit;
   assign rdata        = rd_commit ? arr_rdata : rdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            we_q    <= we;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            wmask_q <= wmask;
         end
         if (rd_commit) begin
            rdata_q <= arr_rdata;
         end
      end
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .raddr (idx_q),
      .rdata (arr_rdata),
      .wen   (wr_commit),
      .waddr (idx_q),
      .wdata (wdata_q),
      .wmask (wmask_q)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 and one at LATENCY=1 with hand-computed expectations.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        en0, en1, we;
   logic [31:0] addr, wdata;
   logic [3:0]  wmask;
   logic [31:0] rd0, rd1;
   logic        rv0, wf0, rv1, wf1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_responder #(.LATENCY(2), .ADDR_W(14)) u0 (
      .clk          (clk),
      .reset        (reset),
      .en           (en0),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .wmask        (wmask),
      .rdata        (rd0),
      .rdata_valid  (rv0),
      .write_finish (wf0)
   );

   dmem_responder #(.LATENCY(1), .ADDR_W(14)) u1 (
      .clk          (clk),
      .reset        (reset),
      .en           (en1),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .wmask        (wmask),
      .rdata        (rd1),
      .rdata_valid  (rv1),
      .write_finish (wf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request on responder sel, scramble the inputs during WAIT, and check the response.
   task automatic req(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] exp_rd, input string tag);
      int   n;
      logic hit;
      logic [31:0] rd;
      logic [1:0]  pulses;
      @(negedge clk);
      we = w; addr = a; wdata = d; wmask = m;
      if (sel == 0) en0 = 1'b1; else en1 = 1'b1;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) begin
            we = ~w; addr = ~a; wdata = ~d; wmask = ~m;
         end
         hit = (sel == 0) ? (rv0 | wf0) : (rv1 | wf1);
      end
      pulses = (sel == 0) ? {rv0, wf0} : {rv1, wf1};
      rd     = (sel == 0) ? rd0 : rd1;
      chk({tag, "_lat"}, 32'(n), (sel == 0) ? 32'd2 : 32'd1);
      chk({tag, "_kind"}, 32'(pulses), w ? 32'b01 : 32'b10);
      if (!w) chk({tag, "_data"}, rd, exp_rd);
      @(posedge clk);
      #1;
      if (sel == 0) en0 = 1'b0; else en1 = 1'b0;
      @(negedge clk);
      pulses = (sel == 0) ? {rv0, wf0} : {rv1, wf1};
      rd     = (sel == 0) ? rd0 : rd1;
      chk({tag, "_nopulse"}, 32'(pulses), 32'b00);
      if (!w) chk({tag, "_hold"}, rd, exp_rd);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      en0 = 1'b0; en1 = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; wmask = '0;
      #12;
      chk("rst_rd0", rd0, 32'h0);
      chk("rst_pulse0", 32'({rv0, wf0}), 32'h0);
      chk("rst_state0", 32'(u0.state_q), 32'(StIdle));
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_pulse1", 32'({rv1, wf1}), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Full-word write/read at LATENCY=2
      req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, "wr10");
      req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, "rd10");

      // Byte-masked writes
      req(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, "wr20");
      req(0, 1'b1, 32'h20, 32'h00AB0000, 4'b0100, 32'h0, "wr20m");
      req(0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11AB3344, "rd20a");
      req(0, 1'b1, 32'h20, 32'hEE0000FF, 4'b1001, 32'h0, "wr20n");
      req(0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hEEAB33FF, "rd20b");

      // Index wrap: 0x0001_0000 aliases word 0
      req(0, 1'b1, 32'h0001_0000, 32'h5A5A5A5A, 4'b1111, 32'h0, "wrwrap");
      req(0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h5A5A5A5A, "rdwrap");

      // Cancel mid-WAIT
      req(0, 1'b1, 32'h30, 32'h12345678, 4'b1111, 32'h0, "wr30");
      @(negedge clk);
      we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; wmask = 4'b1111; en0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("cancel_wait", 32'(u0.state_q), 32'(StWait));
      chk("cancel_nopulse_a", 32'({rv0, wf0}), 32'h0);
      en0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("cancel_nopulse_b", 32'({rv0, wf0}), 32'h0);
      chk("cancel_idle", 32'(u0.state_q), 32'(StIdle));
      chk("cancel_rdhold", rd0, 32'h5A5A5A5A);
      req(0, 1'b0, 32'h30, 32'h0, 4'b0000, 32'h12345678, "rd30");

      // Reset during WAIT of a write
      req(0, 1'b1, 32'h40, 32'h0BADF00D, 4'b1111, 32'h0, "wr40");
      @(negedge clk);
      we = 1'b1; addr = 32'h40; wdata = 32'hFFFFFFFF; wmask = 4'b1111; en0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rstmid_wait", 32'(u0.state_q), 32'(StWait));
      reset = 1'b1;
      en0   = 1'b0;
      #1;
      chk("rstmid_rd", rd0, 32'h0);
      chk("rstmid_pulse", 32'({rv0, wf0}), 32'h0);
      chk("rstmid_state", 32'(u0.state_q), 32'(StIdle));
      chk("rstmid_cnt", 32'(u0.cnt_q), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      req(0, 1'b0, 32'h40, 32'h0, 4'b0000, 32'h0BADF00D, "rd40");

      // Back-to-back reads at LATENCY=1 with en held high
      req(1, 1'b1, 32'h0, 32'h01020304, 4'b1111, 32'h0, "l1wr0");
      req(1, 1'b1, 32'h4, 32'hA0B0C0D0, 4'b1111, 32'h0, "l1wr4");
      @(negedge clk);
      we = 1'b0; addr = 32'h0; wmask = 4'b0000; en1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_p1", 32'({rv1, wf1}), 32'b10);
      chk("b2b_d1", rd1, 32'h01020304);
      addr = 32'h4;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_gap", 32'({rv1, wf1}), 32'b00);
      chk("b2b_gap_hold", rd1, 32'h01020304);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_p2", 32'({rv1, wf1}), 32'b10);
      chk("b2b_d2", rd1, 32'hA0B0C0D0);
      @(posedge clk);
      #1;
      en1 = 1'b0;
      @(negedge clk);
      chk("b2b_end", 32'({rv1, wf1}), 32'b00);
      chk("b2b_end_hold", rd1, 32'hA0B0C0D0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
